layer_serializer: RTL

- Converts one layer's parallel neuron outputs (per-neuron valid vector plus flattened data bus) into the serial word stream that the next layer's neurons consume.
- Emits one word per cycle on x_out/x_valid, in neuron index order.
- Sits between consecutive neural-network layers in the NPU datapath.
- Double-buffered: one result set can be queued while another is streaming.

---
 rtl/nn_config_pkg.sv | 9 +
 rtl/layer_serializer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/nn_config_pkg.sv
// Shared layer geometry so the top level and the layer modules agree on sizes.
package nn_config_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int L1_NN      = 30;
  localparam int L2_NN      = 30;
  localparam int L3_NN      = 10;

endpackage

// File: rtl/layer_serializer.sv
// Turns one layer's parallel outputs into an ascending serial word stream, one word per cycle,
// first word one cycle after capture; no backpressure, so a capture with both buffers full is dropped.
module layer_serializer
  import nn_config_pkg::*;
#(
  parameter int nn         = L1_NN,
  parameter int data_width = DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [nn-1:0]            i_valid,
  input  logic [nn*data_width-1:0] i_data_flat,
  output logic                     x_valid,
  output logic [data_width-1:0]    x_out,
  output logic                     x_last,
  output logic                     busy,
  output logic                     overflow,
  output logic                     partial_err
);

  localparam int CW = (nn > 1) ? $clog2(nn) : 1;
  localparam logic [CW-1:0] LAST = CW'(nn - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [data_width-1:0] act_q  [nn];
  logic [data_width-1:0] pend_q [nn];

  logic capture, partial, last;
  logic ld_act_in, ld_act_pend, ld_pend, drop;

  assign capture = &i_valid;
  assign partial = (|i_valid) & ~capture;
  assign last    = (state_q == STREAM) && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    ld_act_in   = 1'b0;
    ld_act_pend = 1'b0;
    ld_pend     = 1'b0;
    drop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d   = STREAM;
          cnt_d     = '0;
          ld_act_in = 1'b1;
        end
      end
      STREAM: begin
        if (last) begin
          // Handoff: queued set wins, and a simultaneous capture refills the freed slot.
          cnt_d = '0;
          if (pend_vld_q) begin
            ld_act_pend = 1'b1;
            pend_vld_d  = capture;
            ld_pend     = capture;
          end else if (capture) begin
            ld_act_in = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (capture) begin
            if (!pend_vld_q) begin
              ld_pend    = 1'b1;
              pend_vld_d = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_valid = (state_q == STREAM);
    x_out   = x_valid ? act_q[cnt_q] : '0;
    x_last  = x_valid && (cnt_q == LAST);
    busy    = x_valid || pend_vld_q;
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < nn; j++) begin
      if (ld_act_in)
        act_q[j] <= i_data_flat[j*data_width +: data_width];
      else if (ld_act_pend)
        act_q[j] <= pend_q[j];
      if (ld_pend)
        pend_q[j] <= i_data_flat[j*data_width +: data_width];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow    <= 1'b0;
      partial_err <= 1'b0;
    end else begin
      if (drop)    overflow    <= 1'b1;
      if (partial) partial_err <= 1'b1;
    end
  end

endmodule
